// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC vector sequencer.
package mac_pkg;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ACC_W    = 16;
  localparam int DEF_PIPE_LAT = 4;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, OUT} seq_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] weight;
    logic [DEF_DATA_W-1:0] act;
    logic                  last;
  } pair_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/mac_seq_fifo.sv
// Synchronous FIFO of operand pairs; pointers carry an extra wrap bit to tell full from empty.
module mac_seq_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_push,
  input  pair_t i_data,
  input  logic  i_pop,
  output pair_t o_data,
  output logic  o_full,
  output logic  o_empty
);
  localparam int AW = $clog2(DEPTH);

  pair_t      r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic       w_push, w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/mac_vector_sequencer.sv
// Streams buffered weight/activation pairs into a pipelined MAC and returns the dot product.
// Optional MAC_SEQ_ZSKIP_EN: pairs with weight 0 are sent as all-zero so they contribute nothing.
module mac_vector_sequencer
  import mac_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_weight,
  input  logic [DATA_W-1:0] in_act,
  input  logic              in_last,
  output logic [DATA_W-1:0] mac_weight,
  output logic [DATA_W-1:0] mac_act,
  output logic              mac_rst,
  input  logic [ACC_W-1:0]  mac_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_result,
  output logic [7:0]        out_count
);
  localparam int CW = $clog2(PIPE_LAT + 1);

  seq_state_t        r_state;
  logic [CW-1:0]     r_drain;
  logic [DATA_W-1:0] r_mac_weight, r_mac_act;
  logic              r_mac_rst, r_mac_last, r_out_valid;
  logic [ACC_W-1:0]  r_out_result;
  logic [7:0]        r_count;

  pair_t w_wr, w_rd, w_fwd;
  logic  w_full, w_empty, w_push, w_pop;

  assign w_wr     = '{weight: in_weight, act: in_act, last: in_last};
  assign in_ready = !w_full && !reset;
  assign w_push   = in_valid && in_ready;
  // The state tracks what mac_* currently shows, so the pop for the next beat
  // happens in CLEAR (first pair) and in STREAM until the last pair is on the bus.
  assign w_pop    = !w_empty && (r_state == CLEAR || (r_state == STREAM && !r_mac_last));

  mac_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_wr),
    .i_pop   (w_pop),
    .o_data  (w_rd),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_fwd = w_rd;
`ifdef MAC_SEQ_ZSKIP_EN
    if (w_rd.weight == '0) w_fwd.act = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_drain      <= '0;
      r_mac_weight <= '0;
      r_mac_act    <= '0;
      r_mac_rst    <= 1'b0;
      r_mac_last   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_count      <= '0;
    end else begin
      // The MAC has no valid, so every cycle without a pop must present zeros.
      r_mac_rst    <= 1'b0;
      r_mac_weight <= '0;
      r_mac_act    <= '0;
      r_mac_last   <= 1'b0;
      if (w_pop) begin
        r_mac_weight <= w_fwd.weight;
        r_mac_act    <= w_fwd.act;
        r_mac_last   <= w_fwd.last;
        r_count      <= sat_inc8(r_count);
      end
      case (r_state)
        IDLE: if (!w_empty) begin
          r_state   <= CLEAR;
          r_mac_rst <= 1'b1;
          r_count   <= '0;
        end
        CLEAR: r_state <= STREAM;
        STREAM: if (r_mac_last) begin
          r_state <= DRAIN;
          r_drain <= CW'(PIPE_LAT - 1);
        end
        DRAIN: if (r_drain == '0) begin
          r_state      <= OUT;
          r_out_result <= mac_result;
          r_out_valid  <= 1'b1;
        end else begin
          r_drain <= r_drain - 1'b1;
        end
        OUT: if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mac_weight = r_mac_weight;
  assign mac_act    = r_mac_act;
  assign mac_rst    = r_mac_rst;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_count  = r_count;
endmodule

// File: tb/tb_mac_vector_sequencer.sv
// Scoreboard bench for mac_vector_sequencer with a behavioural shift-add MAC model.
module tb_mac_vector_sequencer;
  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_weight = '0, in_act = '0;
  logic        in_ready, mac_rst, out_valid;
  logic [7:0]  mac_weight, mac_act, out_count;
  logic [15:0] mac_result, out_result;

  int checks = 0, passed = 0;
  int rst_cnt = 0, act_cnt = 0;

  typedef struct {logic [15:0] res; logic [7:0] cnt;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mac_vector_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_weight(in_weight), .in_act(in_act), .in_last(in_last),
    .mac_weight(mac_weight), .mac_act(mac_act), .mac_rst(mac_rst),
    .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_count(out_count)
  );

  // MAC model: adds act << (lowest set weight bit) each edge, PL edges to output.
  logic [15:0] m_acc = '0;
  logic [15:0] m_pipe [PL-1] = '{default: '0};

  function automatic logic [15:0] contrib(input logic [7:0] w, input logic [7:0] a);
    for (int b = 0; b < 8; b++) if (w[b]) return 16'(a) << b;
    return 16'(a);
  endfunction

  always @(posedge clk) begin
    m_acc <= mac_rst ? 16'd0 : m_acc + contrib(mac_weight, mac_act);
    m_pipe[0] <= m_acc;
    for (int k = 1; k < PL - 1; k++) m_pipe[k] <= m_pipe[k-1];
  end
  assign mac_result = m_pipe[PL-2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic note_fail(input string nm);
    checks++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mac_rst) rst_cnt++;
      if (mac_act != 0) act_cnt++;
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) note_fail("unexpected_output");
        else begin
          e = sb.pop_front();
          check("out_result", 32'(out_result), 32'(e.res));
          check("out_count", 32'(out_count), 32'(e.cnt));
        end
      end
    end
  end

  task automatic push(input logic [7:0] w, input logic [7:0] a, input logic l);
    int t = 0;
    logic ok;
    in_valid = 1'b1; in_weight = w; in_act = a; in_last = l;
    forever begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
      if (++t > 300) begin note_fail("push_timeout"); break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_valid(input string nm);
    int t = 0;
    do begin
      @(negedge clk);
      if (++t > 200) begin note_fail(nm); break; end
    end while (!out_valid);
  endtask

  task automatic wait_drain(input int bound);
    int t = 0;
    do begin
      @(negedge clk);
      if (++t > bound) begin note_fail("drain_timeout"); break; end
    end while (sb.size() != 0 || out_valid);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, r0, a0;
    // reset state
    @(negedge clk);
    check("rst_mac_weight", 32'(mac_weight), 0);
    check("rst_mac_act", 32'(mac_act), 0);
    check("rst_mac_rst", 32'(mac_rst), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_result", 32'(out_result), 0);
    check("rst_out_count", 32'(out_count), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 1);
    @(posedge clk); #1;

    // 1 basic, out_valid held until out_ready
    out_ready = 1'b0;
    sb.push_back('{16'h0025, 8'd3});
    push(8'h01, 8'd3, 1'b0);
    push(8'h04, 8'd5, 1'b0);
    push(8'h02, 8'd7, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (mac_act != 8'd7 && n < 50);
    check("last_pair_seen", 32'(mac_act), 32'd7);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
    check("result_latency", 32'(n), PL + 1);
    repeat (4) @(negedge clk);
    check("held_out_valid", 32'(out_valid), 1);
    check("held_out_result", 32'(out_result), 32'h0025);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain(100);

    // 2 bubble mid-vector
    sb.push_back('{16'h0025, 8'd3});
    push(8'h01, 8'd3, 1'b0);
    push(8'h04, 8'd5, 1'b0);
    idle(3);
    push(8'h02, 8'd7, 1'b1);
    wait_drain(100);

    // 3 fill the FIFO while stalled in OUT
    out_ready = 1'b0;
    sb.push_back('{16'd1, 8'd1});
    push(8'h01, 8'd1, 1'b1);
    wait_valid("stall_valid_timeout");
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      sb.push_back('{16'(i + 2), 8'd1});
      push(8'h01, 8'(i + 2), 1'b1);
    end
    @(negedge clk);
    check("in_ready_full", 32'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_weight = 8'h01; in_act = 8'h55; in_last = 1'b1;
    idle(2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain(600);

    // 4 back-to-back vectors, one mac_rst pulse each
    r0 = rst_cnt;
    sb.push_back('{16'h000A, 8'd1});
    sb.push_back('{16'h0010, 8'd1});
    push(8'h01, 8'd10, 1'b1);
    push(8'h08, 8'd2, 1'b1);
    wait_drain(100);
    check("mac_rst_pulses", 32'(rst_cnt - r0), 2);

    // 5 zero weight
`ifdef MAC_SEQ_ZSKIP_EN
    sb.push_back('{16'h0001, 8'd2});
`else
    sb.push_back('{16'h000A, 8'd2});
`endif
    push(8'h00, 8'd9, 1'b0);
    push(8'h01, 8'd1, 1'b1);
    wait_drain(100);

    // 6 reset after two of four pairs are driven
    a0 = act_cnt;
    push(8'h01, 8'd1, 1'b0);
    push(8'h01, 8'd2, 1'b0);
    push(8'h01, 8'd4, 1'b0);
    push(8'h01, 8'd8, 1'b0);
    n = 0;
    while (act_cnt - a0 < 2 && n < 50) begin @(negedge clk); n++; end
    check("two_pairs_driven", 32'(act_cnt - a0), 2);
    reset = 1'b1;
    #1;
    check("midrst_mac_act", 32'(mac_act), 0);
    check("midrst_mac_weight", 32'(mac_weight), 0);
    check("midrst_mac_rst", 32'(mac_rst), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_after", 32'(in_ready), 1);
    check("midrst_out_count", 32'(out_count), 0);
    r0 = rst_cnt; a0 = act_cnt;
    idle(8);
    check("fifo_flushed_no_clear", 32'(rst_cnt - r0), 0);
    check("fifo_flushed_no_act", 32'(act_cnt - a0), 0);
    sb.push_back('{16'h0008, 8'd1});
    push(8'h02, 8'd4, 1'b1);
    wait_drain(100);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
